// File: rtl/board_pkg.sv
// Shared definitions for the board control slice.
//   rst_state_t : reset sequencer states
//   BTN_RESET   : button index that drives the system reset
//   BTN_PAGE    : button index that pages the LED monitor
//   safe_clog2  : ceil(log2(value)), never less than 1, for sizing counters/selects
package board_pkg;

  typedef enum logic [1:0] {
    POR,
    RUN,
    HOLD
  } rst_state_t;

  localparam int unsigned BTN_RESET = 0;
  localparam int unsigned BTN_PAGE  = 1;

  function automatic int unsigned safe_clog2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/board_debounce.sv
// Single-button input conditioner: polarity normalisation, two-flop synchroniser,
// stability counter and press-edge detector.
//   clk25 : system clock
//   rst   : synchronous active-high reset
//   pin   : raw asynchronous button pin
//   level : debounced state, 1 = pressed
//   press : one-cycle pulse when level rises
module board_debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk25,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press
);

  localparam int unsigned    CW      = safe_clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          pin_norm;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Normalising ahead of the synchroniser lets the flops reset to 0 = not pressed.
  assign pin_norm = BTN_ACTIVE_LOW ? ~pin : pin;

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= pin_norm;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync2;
        // Only a rising level produces a pulse; releases are silent.
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Board-level control between the raw pins and the system instance.
//   clk25     : system clock (only clock)
//   rst       : synchronous active-high reset
//   button_in : raw button pins
//   monitor   : debug word paged onto the LEDs
//   btn_level : debounced button state, 1 = pressed
//   btn_press : one-cycle pulse per debounced press
//   sys_rst   : stretched active-high reset for downstream logic
//   led       : currently selected monitor slice (registered)
//   led_sel   : current slice index
module board_ctrl
  import board_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned POR_CYCLES      = 1024,
  parameter int unsigned MON_WIDTH       = 16,
  parameter int unsigned LED_WIDTH       = 8
) (
  input  logic                                             clk25,
  input  logic                                             rst,
  input  logic [NUM_BUTTONS-1:0]                           button_in,
  input  logic [MON_WIDTH-1:0]                             monitor,
  output logic [NUM_BUTTONS-1:0]                           btn_level,
  output logic [NUM_BUTTONS-1:0]                           btn_press,
  output logic                                             sys_rst,
  output logic [LED_WIDTH-1:0]                             led,
  output logic [safe_clog2(MON_WIDTH / LED_WIDTH)-1:0]     led_sel
);

  localparam int unsigned    NSLICE  = MON_WIDTH / LED_WIDTH;
  localparam int unsigned    SEL_W   = safe_clog2(NSLICE);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NSLICE - 1);
  localparam int unsigned    PW      = safe_clog2(POR_CYCLES);
  localparam logic [PW-1:0]  POR_MAX = PW'(POR_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    board_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk25(clk25),
      .rst  (rst),
      .pin  (button_in[g]),
      .level(btn_level[g]),
      .press(btn_press[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  rst_state_t  rst_state;
  logic [PW-1:0] por_cnt;

  // sys_rst is assigned alongside each transition so it matches the new state.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rst_state <= POR;
      por_cnt   <= '0;
      sys_rst   <= 1'b1;
    end else begin
      case (rst_state)
        POR: begin
          if (por_cnt == POR_MAX) begin
            por_cnt   <= '0;
            rst_state <= RUN;
            sys_rst   <= 1'b0;
          end else begin
            por_cnt <= por_cnt + 1'b1;
            sys_rst <= 1'b1;
          end
        end
        RUN: begin
          if (btn_level[BTN_RESET]) begin
            rst_state <= HOLD;
            sys_rst   <= 1'b1;
          end else begin
            sys_rst <= 1'b0;
          end
        end
        HOLD: begin
          // Release restarts the stretch so downstream logic sees a full reset.
          if (!btn_level[BTN_RESET]) begin
            rst_state <= POR;
            por_cnt   <= '0;
          end
          sys_rst <= 1'b1;
        end
        default: begin
          rst_state <= POR;
          por_cnt   <= '0;
          sys_rst   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // LED pager
  // ---------------------------------------------------------------------------
  logic [LED_WIDTH-1:0] led_slice;

  always_comb begin
    led_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (led_sel == SEL_W'(i)) begin
        led_slice = monitor[i*LED_WIDTH +: LED_WIDTH];
      end
    end
  end

  // Not gated by sys_rst: the monitor stays visible while the system is held.
  always_ff @(posedge clk25) begin
    if (rst) begin
      led_sel <= '0;
      led     <= '0;
    end else begin
      led <= led_slice;
      if (btn_press[BTN_PAGE]) begin
        led_sel <= (led_sel == SEL_MAX) ? '0 : led_sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: stimulus pushes the expected output snapshot and
// the edge at which it must appear; a monitor pops one entry per observed output change.
module tb_board_ctrl;

  typedef struct packed {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] press;
    logic       sr;
    logic [1:0] sel;
    logic [7:0] led;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  button_in;
  logic [23:0] monitor;
  logic [3:0]  btn_level;
  logic [3:0]  btn_press;
  logic        sys_rst;
  logic [7:0]  led;
  logic [1:0]  led_sel;

  always #5 clk = ~clk;

  board_ctrl #(
    .NUM_BUTTONS    (4),
    .BTN_ACTIVE_LOW (1'b1),
    .DEBOUNCE_CYCLES(8),
    .POR_CYCLES     (16),
    .MON_WIDTH      (24),
    .LED_WIDTH      (8)
  ) dut (
    .clk25    (clk),
    .rst      (rst),
    .button_in(button_in),
    .monitor  (monitor),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .sys_rst  (sys_rst),
    .led      (led),
    .led_sel  (led_sel)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Expected-output model, updated by the stimulus before each push.
  logic [3:0] m_lvl;
  logic [3:0] m_press;
  logic       m_sr;
  logic [1:0] m_sel;
  logic [7:0] m_led;

  task automatic expect_at(input int c);
    snap_t s;
    s.cyc   = c;
    s.lvl   = m_lvl;
    s.press = m_press;
    s.sr    = m_sr;
    s.sel   = m_sel;
    s.led   = m_led;
    exp_q.push_back(s);
  endtask

  // Returns #1 after posedge number c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: any change of the outputs is one DUT event.
  logic [18:0] prev_outs = 'x;
  logic [18:0] cur_outs;
  snap_t       cur;
  snap_t       e;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      cur_outs = {btn_level, btn_press, sys_rst, led_sel, led};
      if (cur_outs !== prev_outs) begin
        cur.cyc   = cyc;
        cur.lvl   = btn_level;
        cur.press = btn_press;
        cur.sr    = sys_rst;
        cur.sel   = led_sel;
        cur.led   = led;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: edge=%0d lvl=%b press=%b sr=%b sel=%0d led=%h, need no change",
                   cur.cyc, cur.lvl, cur.press, cur.sr, cur.sel, cur.led);
        end else begin
          e = exp_q.pop_front();
          if (e !== cur) begin
            errors++;
            $display("FAIL event@%0d: got edge=%0d lvl=%b press=%b sr=%b sel=%0d led=%h, need edge=%0d lvl=%b press=%b sr=%b sel=%0d led=%h",
                     e.cyc, cur.cyc, cur.lvl, cur.press, cur.sr, cur.sel, cur.led,
                     e.cyc, e.lvl, e.press, e.sr, e.sel, e.led);
          end
        end
      end
      prev_outs = cur_outs;
    end
  end

  // One debounced press/release of the page button starting after edge t0.
  task automatic page_press(input int t0, input logic [1:0] sel_n, input logic [7:0] led_n);
    wait_until(t0);
    button_in[1] = 1'b0;
    m_lvl[1]   = 1'b1;
    m_press[1] = 1'b1;
    expect_at(t0 + 10);
    m_press[1] = 1'b0;
    m_sel      = sel_n;
    expect_at(t0 + 11);
    m_led = led_n;
    expect_at(t0 + 12);
    wait_until(t0 + 15);
    button_in[1] = 1'b1;
    m_lvl[1] = 1'b0;
    expect_at(t0 + 25);
  endtask

  initial begin
    rst       = 1'b1;
    button_in = 4'hF;
    monitor   = 24'hA5C33C;
    m_lvl     = 4'h0;
    m_press   = 4'h0;
    m_sr      = 1'b1;
    m_sel     = 2'd0;
    m_led     = 8'h00;

    // Reset values, then POR stretch of 16 cycles.
    expect_at(1);
    wait_until(3);
    rst   = 1'b0;
    m_led = 8'h3C;
    expect_at(4);
    m_sr = 1'b0;
    expect_at(19);

    // 5-cycle glitch on button 2: no event may appear.
    wait_until(20);
    button_in[2] = 1'b0;
    wait_until(25);
    button_in[2] = 1'b1;

    // Three pages: 0->1->2->0.
    page_press(30, 2'd1, 8'hC3);
    page_press(60, 2'd2, 8'hA5);
    page_press(90, 2'd0, 8'h3C);

    // Button 0 held 40 cycles in RUN.
    wait_until(120);
    button_in[0] = 1'b0;
    m_lvl[0]   = 1'b1;
    m_press[0] = 1'b1;
    expect_at(130);
    m_press[0] = 1'b0;
    m_sr       = 1'b1;
    expect_at(131);
    wait_until(160);
    button_in[0] = 1'b1;
    m_lvl[0] = 1'b0;
    expect_at(170);
    m_sr = 1'b0;
    expect_at(187);

    // rst at debounce count 5 aborts the press; full latency needed afterwards.
    wait_until(190);
    button_in[1] = 1'b0;
    wait_until(197);
    rst   = 1'b1;
    m_sr  = 1'b1;
    m_led = 8'h00;
    expect_at(198);
    wait_until(199);
    rst   = 1'b0;
    m_led = 8'h3C;
    expect_at(200);
    m_lvl[1]   = 1'b1;
    m_press[1] = 1'b1;
    expect_at(209);
    m_press[1] = 1'b0;
    m_sel      = 2'd1;
    expect_at(210);
    m_led = 8'hC3;
    expect_at(211);
    m_sr = 1'b0;
    expect_at(215);

    wait_until(230);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, need 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
